fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the decoder. Owns the program

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives both imem read ports and hands
// opcode + optional immediate to the decoder. Optional feature: FETCH_ICOUNT_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  STP_OPC  = 5'b11111
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] instr_addr1,
  output logic [15:0] instr_addr2,
  input  logic [15:0] instr_q1,
  input  logic [15:0] instr_q2,
  input  logic        pc_sload,
  input  logic [15:0] new_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] instr_out,
  output logic [15:0] n_out,
  output logic [15:0] pc_out,
`ifdef FETCH_ICOUNT_EN
  output logic [15:0] icount,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {ISSUE, CAPTURE, HOLD, HALT} state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] n;
    logic [15:0] pc;
  } fetch_rsp_t;

  state_t     state, state_nxt;
  logic [15:0] pc, pc_nxt;
  fetch_rsp_t rsp_q;
  logic       cap, consume, stp;

  assign instr_addr1 = pc;
  assign instr_addr2 = pc + 16'd1;
  assign instr_out   = rsp_q.instr;
  assign n_out       = rsp_q.n;
  assign pc_out      = rsp_q.pc;

  // A redirect flushes, so a handshake on the same edge is not a consume.
  assign consume = out_valid & out_ready & ~pc_sload;
  assign stp     = (instr_q1[15:11] == STP_OPC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ISSUE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cap       = 1'b0;
    if (pc_sload) begin
      state_nxt = ISSUE;
      pc_nxt    = new_pc;
    end else begin
      case (state)
        ISSUE:   state_nxt = (out_valid & ~out_ready) ? HOLD : CAPTURE;
        CAPTURE: begin
          cap = 1'b1;
          if (stp) state_nxt = HALT;
          else begin
            state_nxt = ISSUE;
            pc_nxt    = pc + (instr_q1[11] ? 16'd2 : 16'd1);
          end
        end
        HOLD:    if (out_ready) state_nxt = ISSUE;
        HALT:    state_nxt = HALT;
        default: state_nxt = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      halted    <= 1'b0;
      rsp_q     <= '0;
    end else if (pc_sload) begin
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else if (cap) begin
      out_valid   <= 1'b1;
      rsp_q.instr <= instr_q1;
      rsp_q.n     <= instr_q1[11] ? instr_q2 : 16'h0000;
      rsp_q.pc    <= pc;
      if (stp) halted <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FETCH_ICOUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       icount <= 16'h0000;
    else if (consume) icount <= icount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// ready/redirect traffic against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr_addr1, instr_addr2;
  logic [15:0] instr_q1 = 16'h0, instr_q2 = 16'h0;
  logic        pc_sload = 1'b0;
  logic [15:0] new_pc = 16'h0;
  logic        out_ready = 1'b1;
  logic        out_valid, halted;
  logic [15:0] instr_out, n_out, pc_out;
`ifdef FETCH_ICOUNT_EN
  logic [15:0] icount;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] mem [65536];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .instr_addr1(instr_addr1), .instr_addr2(instr_addr2),
    .instr_q1(instr_q1), .instr_q2(instr_q2),
    .pc_sload(pc_sload), .new_pc(new_pc),
    .out_ready(out_ready), .out_valid(out_valid),
    .instr_out(instr_out), .n_out(n_out), .pc_out(pc_out),
`ifdef FETCH_ICOUNT_EN
    .icount(icount),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, one cycle read latency on both ports.
  always @(posedge clk) begin
    instr_q1 <= mem[instr_addr1];
    instr_q2 <= mem[instr_addr2];
  end

  // Model: a fetch is one address cycle then one return cycle; a pending
  // output blocks the next address cycle, and once blocked a fresh address
  // cycle is needed after the output drains.
  typedef struct {
    logic [15:0] pc;
    bit          reading;
    bit          blocked;
    bit          valid;
    logic [15:0] instr, n, pco, icnt;
    bit          halted;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.pc = 16'h0000; r.reading = 0; r.blocked = 0; r.valid = 0;
    r.instr = 16'h0; r.n = 16'h0; r.pco = 16'h0; r.icnt = 16'h0; r.halted = 0;
    return r;
  endfunction

  function automatic model_t step(input model_t s, input logic rdy, input logic sl,
                                  input logic [15:0] np);
    model_t r = s;
    logic [15:0] w, a2;
    if (sl) begin
      r.pc = np; r.reading = 0; r.blocked = 0; r.valid = 0; r.halted = 0;
      return r;
    end
    if (s.valid && rdy) begin
      r.valid = 0;
      r.icnt  = s.icnt + 16'd1;
    end
    if (s.halted) return r;
    if (s.reading) begin
      w  = mem[s.pc];
      a2 = s.pc + 16'd1;
      r.reading = 0;
      r.valid   = 1;
      r.instr   = w;
      r.n       = w[11] ? mem[a2] : 16'h0000;
      r.pco     = s.pc;
      if (w[15:11] == 5'h1f) r.halted = 1;
      else r.pc = s.pc + (w[11] ? 16'd2 : 16'd1);
    end else if (s.blocked) begin
      if (rdy) r.blocked = 0;
    end else if (s.valid && !rdy) begin
      r.blocked = 1;
    end else begin
      r.reading = 1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= step(m, out_ready, pc_sload, new_pc);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_addr1", instr_addr1, m.pc);
      chk("m_addr2", instr_addr2, m.pc + 16'd1);
      chk("m_valid", {15'h0, out_valid}, {15'h0, m.valid});
      chk("m_halted", {15'h0, halted}, {15'h0, m.halted});
      if (m.valid) begin
        chk("m_instr", instr_out, m.instr);
        chk("m_n", n_out, m.n);
        chk("m_pc_out", pc_out, m.pco);
      end
`ifdef FETCH_ICOUNT_EN
      chk("m_icount", icount, m.icnt);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_out(input logic [15:0] pc, input int budget, input string nm);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc();
      if (out_valid && pc_out == pc) ok = 1;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: no out_valid with pc_out=%h within %0d cycles", nm, pc, budget);
    end
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
    end
    mem[0] = 16'h4012; mem[1] = 16'h0001; mem[2] = 16'h0002; mem[3] = 16'h0003;
    mem[4] = 16'h2800; mem[5] = 16'h00A5; mem[6] = 16'h1000; mem[7] = 16'h1001;
    mem[8] = 16'hF800;
    mem[16'h10] = 16'h0100; mem[16'h11] = 16'h0101;
    mem[16'h30] = 16'h0300; mem[16'h31] = 16'h0301;
    mem[16'hFFFF] = 16'h0800;

    // Reset state
    repeat (2) cyc();
    chk("rst_valid", {15'h0, out_valid}, 16'h0);
    chk("rst_instr", instr_out, 16'h0);
    chk("rst_n_out", n_out, 16'h0);
    chk("rst_pc_out", pc_out, 16'h0);
    chk("rst_halted", {15'h0, halted}, 16'h0);
    chk("rst_addr1", instr_addr1, 16'h0000);
    chk("rst_addr2", instr_addr2, 16'h0001);
    @(negedge clk); rst_n = 1'b1;

    // First fetch two cycles after reset release
    cyc(); cyc();
    chk("t1_valid", {15'h0, out_valid}, 16'h1);
    chk("t1_instr", instr_out, 16'h4012);
    chk("t1_n", n_out, 16'h0);
    chk("t1_pc", pc_out, 16'h0);
    chk("t1_addr1", instr_addr1, 16'h0001);

    // Type-I fetch
    wait_out(16'h0004, 12, "t2_wait");
    chk("t2_instr", instr_out, 16'h2800);
    chk("t2_n", n_out, 16'h00A5);
    chk("t2_addr1", instr_addr1, 16'h0006);
    chk("t2_addr2", instr_addr2, 16'h0007);

    // Backpressure: output and addresses frozen
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_valid", {15'h0, out_valid}, 16'h1);
      chk("t3_pc", pc_out, 16'h0004);
      chk("t3_addr1", instr_addr1, 16'h0006);
    end
    out_ready = 1'b1;
    wait_out(16'h0006, 6, "t3_resume");

    // Redirect during the return cycle drops the captured word
    cyc();
    pc_sload = 1'b1; new_pc = 16'h0030;
    cyc();
    pc_sload = 1'b0;
    chk("t4_valid", {15'h0, out_valid}, 16'h0);
    chk("t4_addr1", instr_addr1, 16'h0030);
    wait_out(16'h0030, 4, "t4_first");
    chk("t4_instr", instr_out, 16'h0300);

    // STP halts, redirect restarts
    pc_sload = 1'b1; new_pc = 16'h0008;
    cyc();
    pc_sload = 1'b0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cyc();
      if (halted) seen = 1;
    end
    chk("t5_halt_seen", {15'h0, seen}, 16'h1);
    chk("t5_instr", instr_out, 16'hF800);
    chk("t5_pc", pc_out, 16'h0008);
    repeat (6) cyc();
    chk("t5_no_valid", {15'h0, out_valid}, 16'h0);
    chk("t5_addr1", instr_addr1, 16'h0008);
    chk("t5_halted", {15'h0, halted}, 16'h1);
    pc_sload = 1'b1; new_pc = 16'h0010;
    cyc();
    pc_sload = 1'b0;
    chk("t5_unhalt", {15'h0, halted}, 16'h0);
    chk("t5_addr_10", instr_addr1, 16'h0010);
    wait_out(16'h0010, 4, "t5_restart");

    // Address wrap
    pc_sload = 1'b1; new_pc = 16'hFFFF;
    cyc();
    pc_sload = 1'b0;
    chk("t6_addr1", instr_addr1, 16'hFFFF);
    chk("t6_addr2", instr_addr2, 16'h0000);
    wait_out(16'hFFFF, 4, "t6_wait");
    chk("t6_n", n_out, 16'h4012);
    chk("t6_wrap_pc", instr_addr1, 16'h0001);

    // Random ready / redirect traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      pc_sload  = ($urandom_range(0, 11) == 0);
      new_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cyc();
    end
    pc_sload = 1'b0; out_ready = 1'b1;

    // Asynchronous reset in the middle of a return cycle
    pc_sload = 1'b1; new_pc = 16'h0010;
    cyc();
    pc_sload = 1'b0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {15'h0, out_valid}, 16'h0);
    chk("ar_instr", instr_out, 16'h0);
    chk("ar_n", n_out, 16'h0);
    chk("ar_pc_out", pc_out, 16'h0);
    chk("ar_halted", {15'h0, halted}, 16'h0);
    chk("ar_addr1", instr_addr1, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Three consumes then a flush of the fourth output
    wait_out(16'h0000, 4, "ic_first");
    chk("ic_instr0", instr_out, 16'h4012);
    wait_out(16'h0003, 10, "ic_fourth");
    pc_sload = 1'b1; new_pc = 16'h0030;
    cyc();
    pc_sload = 1'b0;
    chk("ic_flushed", {15'h0, out_valid}, 16'h0);
`ifdef FETCH_ICOUNT_EN
    chk("ic_count", icount, 16'd3);
`endif
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
